// File: rtl/dct_pkg.sv
// ----------------------------------------------------------------------------
// dct_pkg
// Shared constants for the 8-point column DCT engine:
//   - 6-bit-fraction DCT-II coefficients A..G and the fraction shift
//   - default datapath widths
//   - COEF: the full 8x8 coefficient matrix (row k = output Y[k], col n = x[n])
//   - saturate(): clamps an integer into a signed field of a given width
// ----------------------------------------------------------------------------
package dct_pkg;

    // round(64 * 1/2 * c_k * cos((2n+1) k pi / 16))
    localparam int COEF_A = 23;  // c4
    localparam int COEF_B = 31;  // c1
    localparam int COEF_C = 30;  // c2
    localparam int COEF_D = 27;  // c3
    localparam int COEF_E = 18;  // c5
    localparam int COEF_F = 12;  // c6
    localparam int COEF_G = 6;   // c7

    localparam int FRAC_SHIFT = 6;

    localparam int DEF_SIZE      = 8;
    localparam int DEF_SIZE_MULT = DEF_SIZE + 6;
    localparam int DEF_SIZE_OUT  = DEF_SIZE + 2;

    // Even rows are symmetric and odd rows antisymmetric about n=3.5, which is
    // what lets the butterfly sums/differences stand in for columns 4..7.
    localparam int COEF [8][8] = '{
        '{ COEF_A,  COEF_A,  COEF_A,  COEF_A,  COEF_A,  COEF_A,  COEF_A,  COEF_A},
        '{ COEF_B,  COEF_D,  COEF_E,  COEF_G, -COEF_G, -COEF_E, -COEF_D, -COEF_B},
        '{ COEF_C,  COEF_F, -COEF_F, -COEF_C, -COEF_C, -COEF_F,  COEF_F,  COEF_C},
        '{ COEF_D, -COEF_G, -COEF_B, -COEF_E,  COEF_E,  COEF_B,  COEF_G, -COEF_D},
        '{ COEF_A, -COEF_A, -COEF_A,  COEF_A,  COEF_A, -COEF_A, -COEF_A,  COEF_A},
        '{ COEF_E, -COEF_B,  COEF_G,  COEF_D, -COEF_D, -COEF_G,  COEF_B, -COEF_E},
        '{ COEF_F, -COEF_C,  COEF_C, -COEF_F, -COEF_F,  COEF_C, -COEF_C,  COEF_F},
        '{ COEF_G, -COEF_E,  COEF_D, -COEF_B,  COEF_B, -COEF_D,  COEF_E, -COEF_G}
    };

    // Clamp v into [-2^(w-1), 2^(w-1)-1].
    function automatic int saturate(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/dct_butterfly8.sv
// ----------------------------------------------------------------------------
// dct_butterfly8
// Combinational even/odd pre-add stage of the 8-point DCT.
//   x_i    : 8 signed samples, SIZE bits each (x_i[n] = x[n])
//   sum_o  : sum_o[n]  = x[n] + x[7-n], n = 0..3, signed SIZE+1 bits
//   diff_o : diff_o[n] = x[n] - x[7-n], n = 0..3, signed SIZE+1 bits
// ----------------------------------------------------------------------------
module dct_butterfly8 #(
    parameter int SIZE = 8
) (
    input  logic [7:0][SIZE-1:0] x_i,
    output logic [3:0][SIZE:0]   sum_o,
    output logic [3:0][SIZE:0]   diff_o
);

    always_comb begin
        sum_o  = '0;
        diff_o = '0;
        for (int n = 0; n < 4; n++) begin
            sum_o[n]  = (SIZE+1)'($signed(x_i[n])) + (SIZE+1)'($signed(x_i[7-n]));
            diff_o[n] = (SIZE+1)'($signed(x_i[n])) - (SIZE+1)'($signed(x_i[7-n]));
        end
    end

endmodule

// File: rtl/dct_col8.sv
// ----------------------------------------------------------------------------
// dct_col8
// Single-column 8-point 1-D DCT-II, fixed point, 1-clock latency, with
// optional per-product LSB truncation.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   data_in   : 8 signed samples x[0..7], SIZE bits each
//   start     : sample data_in/approx_en and load a new result this edge
//   wr_en     : output-update qualifier from the stage controller
//   approx_en : zero APPROX_BITS LSBs of every product
//   data_out  : registered coefficients Y[0..7], signed SIZE_OUT bits each
//   done      : registered; data_out holds a fresh result
//
// Handshake: start=1 always loads a new result and raises done (wr_en is
// ignored, so back-to-back starts keep done high). With start=0, wr_en=1
// acknowledges the result by clearing done while data_out holds; with both
// low, everything freezes.
// ----------------------------------------------------------------------------
module dct_col8
    import dct_pkg::*;
#(
    parameter int SIZE        = DEF_SIZE,
    parameter int APPROX_BITS = 0,
    parameter int SIZE_MULT   = SIZE + 6,
    parameter int SIZE_OUT    = SIZE + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0][SIZE-1:0]     data_in,
    input  logic                     start,
    input  logic                     wr_en,
    input  logic                     approx_en,
    output logic [7:0][SIZE_OUT-1:0] data_out,
    output logic                     done
);

    localparam int SUM_W = SIZE_MULT + 3;

    // Keeps the upper SIZE_MULT-APPROX_BITS bits of a product.
    localparam logic [SIZE_MULT-1:0] TRUNC_MASK = {SIZE_MULT{1'b1}} << APPROX_BITS;

    logic [3:0][SIZE:0]          bf_sum;
    logic [3:0][SIZE:0]          bf_diff;
    logic [7:0][SIZE_OUT-1:0]    coef_y;
    logic                        trunc_active;

    logic [7:0][SIZE_OUT-1:0]    data_out_d, data_out_q;
    logic                        done_d, done_q;

    dct_butterfly8 #(
        .SIZE(SIZE)
    ) u_butterfly (
        .x_i   (data_in),
        .sum_o (bf_sum),
        .diff_o(bf_diff)
    );

    assign trunc_active = (APPROX_BITS != 0) && approx_en;

    // Without truncation the butterfly form (4 products per row) is exact.
    // With truncation each product of the matrix form must be cut on its
    // own, since trunc(c*a)+trunc(c*b) != trunc(c*(a+b)); that path therefore
    // uses all 8 per-sample products.
    always_comb begin
        logic signed [SIZE_MULT-1:0] cm;
        logic signed [SIZE_MULT-1:0] xm;
        logic signed [SIZE_MULT-1:0] prod;
        logic signed [SUM_W-1:0]     acc;
        coef_y = '0;
        cm     = '0;
        xm     = '0;
        prod   = '0;
        acc    = '0;
        for (int k = 0; k < 8; k++) begin
            acc = '0;
            if (trunc_active) begin
                for (int n = 0; n < 8; n++) begin
                    cm   = SIZE_MULT'(COEF[k][n]);
                    xm   = SIZE_MULT'($signed(data_in[n]));
                    prod = (cm * xm) & TRUNC_MASK;
                    acc  = acc + SUM_W'(prod);
                end
            end else begin
                for (int n = 0; n < 4; n++) begin
                    cm   = SIZE_MULT'(COEF[k][n]);
                    xm   = (k % 2 == 0) ? SIZE_MULT'($signed(bf_sum[n]))
                                        : SIZE_MULT'($signed(bf_diff[n]));
                    prod = cm * xm;
                    acc  = acc + SUM_W'(prod);
                end
            end
            // Arithmetic shift floors; saturation then bounds the output field.
            coef_y[k] = SIZE_OUT'(saturate(int'(acc >>> FRAC_SHIFT), SIZE_OUT));
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        done_d     = done_q;
        if (start) begin
            data_out_d = coef_y;
            done_d     = 1'b1;
        end else if (wr_en) begin
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dct_col8.sv
module tb_dct_col8;

  localparam int SIZE     = 8;
  localparam int SIZE_OUT = 10;
  localparam int VEC_W    = 8 * SIZE_OUT;
  localparam int AB_AP    = 4;

  logic                     clk;
  logic                     rst;
  logic [7:0][SIZE-1:0]     data_in;
  logic                     start;
  logic                     wr_en;
  logic                     approx_en;
  logic [7:0][SIZE_OUT-1:0] data_out;
  logic                     done;
  logic [7:0][SIZE_OUT-1:0] data_out_ap;
  logic                     done_ap;

  int checks = 0;
  int errors = 0;

  logic [VEC_W-1:0] exp_q[$];
  logic [VEC_W-1:0] exp_ap_q[$];
  logic [VEC_W-1:0] last_exp;
  logic [VEC_W-1:0] last_exp_ap;

  int col[8];

  // Reference matrix, written out independently of the design package.
  int ref_m [8][8] = '{
    '{ 23,  23,  23,  23,  23,  23,  23,  23},
    '{ 31,  27,  18,   6,  -6, -18, -27, -31},
    '{ 30,  12, -12, -30, -30, -12,  12,  30},
    '{ 27,  -6, -31, -18,  18,  31,   6, -27},
    '{ 23, -23, -23,  23,  23, -23, -23,  23},
    '{ 18, -31,   6,  27, -27,  -6,  31, -18},
    '{ 12, -30,  30, -12, -12,  30, -30,  12},
    '{  6, -18,  27, -31,  31, -27,  18,  -6}
  };

  dct_col8 #(.SIZE(SIZE), .APPROX_BITS(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .start    (start),
    .wr_en    (wr_en),
    .approx_en(approx_en),
    .data_out (data_out),
    .done     (done)
  );

  dct_col8 #(.SIZE(SIZE), .APPROX_BITS(AB_AP)) dut_ap (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .start    (start),
    .wr_en    (wr_en),
    .approx_en(approx_en),
    .data_out (data_out_ap),
    .done     (done_ap)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [VEC_W-1:0] model(input int ab, input bit ap);
    logic [VEC_W-1:0] v;
    int acc;
    int p;
    int y;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int n = 0; n < 8; n++) begin
        p = ref_m[k][n] * col[n];
        if (ap && ab > 0) p = (p >>> ab) <<< ab;
        acc += p;
      end
      y = acc >>> 6;
      if (y > 511) y = 511;
      if (y < -512) y = -512;
      v[k*SIZE_OUT +: SIZE_OUT] = SIZE_OUT'(y);
    end
    return v;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_y(input string tag, input int k, input int val);
    logic [SIZE_OUT-1:0] e;
    e = SIZE_OUT'(val);
    check(tag, VEC_W'(data_out[k]), VEC_W'(e));
  endtask

  task automatic check_out();
    if (exp_q.size() == 0 || exp_ap_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      last_exp    = exp_q.pop_front();
      last_exp_ap = exp_ap_q.pop_front();
      check("data_out", data_out, last_exp);
      check("done", VEC_W'(done), VEC_W'(1'b1));
      check("data_out_ap", data_out_ap, last_exp_ap);
      check("done_ap", VEC_W'(done_ap), VEC_W'(1'b1));
    end
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge: drive a column with start=1, push the
  // expectation, advance one edge and compare.
  task automatic step(input bit ap);
    for (int n = 0; n < 8; n++) data_in[n] = SIZE'(col[n]);
    approx_en = ap;
    start     = 1'b1;
    wr_en     = 1'($urandom_range(0, 1));
    exp_q.push_back(model(0, ap));
    exp_ap_q.push_back(model(AB_AP, ap));
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic fill(input int v);
    for (int n = 0; n < 8; n++) col[n] = v;
  endtask

  task automatic idle(input bit we, input int cycles);
    start = 1'b0;
    wr_en = we;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  int imp_exp[8] = '{23, 31, 30, 27, 23, 18, 12, 6};

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b0;
    start     = 1'b1;
    wr_en     = 1'b1;
    approx_en = 1'b0;
    for (int n = 0; n < 8; n++) data_in[n] = SIZE'($urandom_range(0, 255));

    // Reset held with active start and random data
    repeat (3) begin
      @(posedge clk);
      for (int n = 0; n < 8; n++) data_in[n] = SIZE'($urandom_range(0, 255));
      approx_en = 1'($urandom_range(0, 1));
    end
    #1;
    check("rst_data", data_out, '0);
    check("rst_done", VEC_W'(done), '0);
    check("rst_data_ap", data_out_ap, '0);
    check("rst_done_ap", VEC_W'(done_ap), '0);

    // Release with start=0: nothing changes
    start = 1'b0;
    wr_en = 1'b0;
    rst   = 1'b1;
    idle(1'b0, 2);
    check("post_rst_data", data_out, '0);
    check("post_rst_done", VEC_W'(done), '0);

    // DC column
    fill(10);
    step(1'b0);
    check_y("dc_y0", 0, 28);
    for (int k = 1; k < 8; k++) check_y("dc_ac", k, 0);
    idle(1'b1, 1);
    check("ack_done", VEC_W'(done), '0);
    check_y("ack_y0_hold", 0, 28);

    // Impulse on x0
    fill(0);
    col[0] = 64;
    step(1'b0);
    for (int k = 0; k < 8; k++) check_y("impulse", k, imp_exp[k]);

    // Extremes
    fill(127);
    step(1'b0);
    check_y("max_y0", 0, 365);
    for (int k = 1; k < 8; k++) check_y("max_ac", k, 0);
    fill(-128);
    step(1'b0);
    check_y("min_y0", 0, -368);
    for (int k = 1; k < 8; k++) check_y("min_ac", k, 0);
    for (int n = 0; n < 8; n++) col[n] = (n % 2 == 0) ? 100 : -100;
    step(1'b0);
    check_y("alt_y7", 7, 256);
    check_y("alt_y1", 1, 50);

    // Approximation
    fill(2);
    step(1'b1);
    check("ap_on_y0", VEC_W'(data_out_ap[0]), VEC_W'(10'sd4));
    check_y("ap_no_effect_y0", 0, 5);
    step(1'b0);
    check("ap_off_y0", VEC_W'(data_out_ap[0]), VEC_W'(10'sd5));

    // Streaming: 8 back-to-back columns, done stays high
    for (int i = 0; i < 8; i++) begin
      for (int n = 0; n < 8; n++) col[n] = $urandom_range(0, 255) - 128;
      step(1'($urandom_range(0, 1)));
    end

    // Freeze: outputs and done hold
    idle(1'b0, 3);
    check("freeze_data", data_out, last_exp);
    check("freeze_done", VEC_W'(done), VEC_W'(1'b1));
    check("freeze_data_ap", data_out_ap, last_exp_ap);

    // Async reset mid-stream
    for (int n = 0; n < 8; n++) col[n] = $urandom_range(0, 255) - 128;
    step(1'b0);
    for (int n = 0; n < 8; n++) data_in[n] = SIZE'($urandom_range(0, 255));
    start = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_data", data_out, '0);
    check("async_rst_done", VEC_W'(done), '0);
    check("async_rst_data_ap", data_out_ap, '0);
    @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b1;
    idle(1'b0, 2);
    check("rst_release_data", data_out, '0);
    check("rst_release_done", VEC_W'(done), '0);

    // Recovery
    for (int n = 0; n < 8; n++) col[n] = $urandom_range(0, 255) - 128;
    step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
